// File: rtl/moving_avg_recursive_pkg.sv
// Shared defaults and sign-extension helper for the recursive moving-average filter.
package mavg_pkg;
  localparam int DW_DEF    = 10;
  localparam int LOG2N_DEF = 2;
  localparam int SEXT_W    = 32;
  localparam int SEXT_IW   = $clog2(SEXT_W);

  // Replicates bit (width-1) of x into all higher bits of the result.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] x, input int width);
    logic [SEXT_W-1:0]  r;
    logic [SEXT_IW-1:0] msb;
    msb = SEXT_IW'(width - 1);
    for (int i = 0; i < SEXT_W; i++)
      r[i] = (i < width) ? x[i] : x[msb];
    return r;
  endfunction
endpackage

// File: rtl/moving_avg_recursive_arith.sv
// Ripple-carry arithmetic cells: full adder, W-bit adder, W-bit subtractor (A + ~B + 1).
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_w #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);
  logic [W-1:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < W-1; i++) begin : g_fa
    fulladder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  // Result is mod 2^W, so the top bit needs no carry-out.
  assign s[W-1] = a[W-1] ^ b[W-1] ^ c[W-1];
endmodule

module subtractor_w #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] d
);
  logic [W-1:0] c;
  logic [W-1:0] nb;
  assign nb   = ~b;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < W-1; i++) begin : g_fa
    fulladder u_fa (.a(a[i]), .b(nb[i]), .ci(c[i]), .s(d[i]), .co(c[i+1]));
  end
  assign d[W-1] = a[W-1] ^ nb[W-1] ^ c[W-1];
endmodule

// File: rtl/moving_avg_recursive.sv
// Recursive N-tap moving average: sum += new - oldest, one add and one subtract per sample.
module moving_avg_recursive
  import mavg_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int LOG2N = LOG2N_DEF,
  localparam int SW    = DW + LOG2N,
  localparam int N     = 1 << LOG2N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [SW-1:0] out_sum,
  output logic [DW-1:0] out_avg,
  output logic          out_full
);
  localparam logic [LOG2N:0] CNT_FULL = {1'b1, {LOG2N{1'b0}}};

  logic [N-1:0][DW-1:0] dline_q, dline_d;
  logic [LOG2N-1:0]     wp_q, wp_d;
  logic [LOG2N:0]       cnt_q, cnt_d;
  logic [SW-1:0]        sum_q, sum_d;
  logic                 vld_q, vld_d;

  logic [DW-1:0] x_old;
  logic [SW-1:0] in_ext, old_ext, acc, sum_nxt;

  assign x_old   = dline_q[wp_q];
  assign in_ext  = SW'(sext(SEXT_W'(in_data), DW));
  assign old_ext = SW'(sext(SEXT_W'(x_old), DW));

  adder_w      #(.W(SW)) u_add (.a(sum_q), .b(in_ext),  .s(acc));
  subtractor_w #(.W(SW)) u_sub (.a(acc),   .b(old_ext), .d(sum_nxt));

  always_comb begin
    dline_d = dline_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    vld_d   = 1'b0;
    if (clr) begin
      // Flush beats a coincident sample; the sample is dropped.
      dline_d = '0;
      wp_d    = '0;
      cnt_d   = '0;
      sum_d   = '0;
    end else if (in_valid) begin
      dline_d[wp_q] = in_data;
      wp_d          = wp_q + 1'b1;
      cnt_d         = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
      sum_d         = sum_nxt;
      vld_d         = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dline_q <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      dline_q <= dline_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      vld_q   <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign out_sum   = sum_q;
  // Dropping the low LOG2N bits of the sum is an arithmetic shift, flooring toward -inf.
  assign out_avg   = sum_q[SW-1:LOG2N];
  assign out_full  = (cnt_q == CNT_FULL);
endmodule

// File: tb/tb_moving_avg_recursive.sv
// Scoreboard bench: a window-queue reference model predicts every cycle's outputs.
module tb_moving_avg_recursive;
  localparam int DW    = 10;
  localparam int LOG2N = 2;
  localparam int SW    = DW + LOG2N;
  localparam int N     = 1 << LOG2N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [SW-1:0] out_sum;
  logic [DW-1:0] out_avg;
  logic          out_full;

  moving_avg_recursive #(.DW(DW), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_sum(out_sum), .out_avg(out_avg), .out_full(out_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [SW-1:0] sum;
    logic [DW-1:0] avg;
    logic          full;
    string         tag;
  } exp_t;

  exp_t exp_q[$];
  int   win[$];
  int   errors = 0;
  int   checks = 0;
  bit   done = 0;

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  // Drive one cycle at the falling edge and queue what the outputs must show after the next rise.
  task automatic step(input logic r, input logic c, input logic v, input int x, input string tag);
    exp_t e;
    int   s;
    @(negedge clk);
    rst = r; clr = c; in_valid = v; in_data = DW'(x);
    if (r || c) win.delete();
    else if (v) begin
      win.push_back(x);
      if (win.size() > N) void'(win.pop_front());
    end
    s = 0;
    foreach (win[i]) s += win[i];
    e.v    = v && !r && !c;
    e.sum  = SW'(s);
    e.avg  = DW'(floor_div(s, N));
    e.full = (win.size() == N);
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic smp(input int x, input string tag);
    step(1'b0, 1'b0, 1'b1, x, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 1'b0, 0, tag);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation after each rising edge.
  initial begin
    while (!done || exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== e.v || out_sum !== e.sum || out_avg !== e.avg || out_full !== e.full) begin
          errors++;
          $display("FAIL %s: got v=%0b sum=%0d avg=%0d full=%0b, want v=%0b sum=%0d avg=%0d full=%0b",
                   e.tag, out_valid, $signed(out_sum), $signed(out_avg), out_full,
                   e.v, $signed(e.sum), $signed(e.avg), e.full);
        end
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 1'b0, 0, "reset");
    step(1'b1, 1'b0, 1'b1, 55, "reset_with_valid");
    // Ramp
    for (int i = 1; i <= 5; i++) smp(4 * i, "ramp");
    // Negative floor
    step(1'b1, 1'b0, 1'b0, 0, "reset2");
    smp(-1, "neg_single");
    for (int i = 0; i < 3; i++) smp(-1, "neg_fill");
    // Extremes
    for (int i = 0; i < 4; i++) smp(511, "max");
    for (int i = 0; i < 4; i++) smp(-512, "min");
    // Gapped valid
    step(1'b0, 1'b1, 1'b0, 0, "clr_idle");
    smp(10, "gap_a");
    for (int i = 0; i < 3; i++) idle("gap_hold");
    smp(20, "gap_b");
    idle("gap_after");
    // Flush with coincident sample
    for (int i = 0; i < 4; i++) smp(100, "fill100");
    step(1'b0, 1'b1, 1'b1, 7, "clr_wins");
    smp(7, "after_clr");
    // Pointer wrap
    step(1'b1, 1'b0, 1'b0, 0, "reset3");
    for (int i = 1; i <= 12; i++) smp(i, "wrap");
    // Mid-stream reset then random traffic
    step(1'b1, 1'b0, 1'b1, 3, "reset_mid");
    for (int i = 0; i < 400; i++) begin
      int  r;
      int  x;
      logic c, v;
      r = int'($urandom_range(0, 99));
      x = int'($signed(DW'($urandom)));
      c = (r < 3);
      v = (r < 75);
      if (r == 99) step(1'b1, 1'b0, 1'b1, x, "rand_rst");
      else         step(1'b0, c, v, x, "rand");
    end
    idle("drain");
    done = 1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
